// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

   // Operation codes as presented on alu_control_i; 1011-1111 are unassigned
   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLT  = 4'b0101,
      OP_SLL  = 4'b0110,
      OP_SLTU = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_SUBU = 4'b1010
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_core.sv
// Single-cycle arithmetic/logic for all non-shift operations.
// Latency: combinational.
// Backpressure: none; shift ops pass operand_a through (only used for shift-by-0).
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   output logic [WIDTH-1:0] result_o
);

   // Add/sub wrap naturally at WIDTH bits; compares yield 1/0
   always_comb begin
      result_o = operand_a_i;
      case (op_i)
         OP_ADD:  result_o = operand_a_i + operand_b_i;
         OP_SUB:  result_o = operand_a_i - operand_b_i;
         OP_SUBU: result_o = operand_a_i - operand_b_i;
         OP_AND:  result_o = operand_a_i & operand_b_i;
         OP_OR:   result_o = operand_a_i | operand_b_i;
         OP_XOR:  result_o = operand_a_i ^ operand_b_i;
         OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
         OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
         default: result_o = operand_a_i;
      endcase
   end

endmodule

// File: rtl/alu_decoder.sv
// Maps the raw 4-bit control code onto an operation, a shift flag and an illegal flag.
// Latency: combinational.
// Backpressure: none, pure decode.
module alu_decoder
   import alu_pkg::*;
(
   input  logic [3:0] code_i,
   output alu_op_e    op_o,
   output logic       is_shift_o,
   output logic       illegal_o
);

   // Unassigned codes decode as a harmless add and raise the illegal flag;
   // the caller forces the result to zero for them.
   always_comb begin
      op_o       = OP_ADD;
      is_shift_o = 1'b0;
      illegal_o  = 1'b0;
      case (code_i)
         4'b0000: op_o = OP_ADD;
         4'b0001: op_o = OP_SUB;
         4'b0010: op_o = OP_AND;
         4'b0011: op_o = OP_OR;
         4'b0100: op_o = OP_XOR;
         4'b0101: op_o = OP_SLT;
         4'b0110: begin op_o = OP_SLL; is_shift_o = 1'b1; end
         4'b0111: op_o = OP_SLTU;
         4'b1000: begin op_o = OP_SRL; is_shift_o = 1'b1; end
         4'b1001: begin op_o = OP_SRA; is_shift_o = 1'b1; end
         4'b1010: op_o = OP_SUBU;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus bit-serial shifts, one request in flight.
// Latency: 1 cycle for non-shift ops and shift-by-0, k+1 cycles for a shift by k.
// Backpressure: result held in DONE until out_ready_i; in_ready_o only in IDLE without flush.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       alu_control_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             illegal_o
);

   state_e             state;
   alu_op_e            shift_op;
   logic [WIDTH-1:0]   shift_reg;
   logic [WIDTH-1:0]   shift_nxt;
   logic [SHAMT_W-1:0] shift_cnt;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   result_q;
   logic               out_valid_q;
   logic               zero_q;
   logic               illegal_q;

   alu_op_e            dec_op;
   logic               dec_shift;
   logic               dec_illegal;
   logic [WIDTH-1:0]   core_res;
   logic [WIDTH-1:0]   idle_res;
   logic               accept;

   assign in_ready_o  = (state == IDLE) && !flush_i;
   assign accept      = in_valid_i && in_ready_o;
   assign shamt       = operand_b_i[SHAMT_W-1:0];
   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign zero_o      = zero_q;
   assign illegal_o   = illegal_q;

   alu_decoder u_decoder (
      .code_i     (alu_control_i),
      .op_o       (dec_op),
      .is_shift_o (dec_shift),
      .illegal_o  (dec_illegal)
   );

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op_i        (dec_op),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .result_o    (core_res)
   );

   // Unassigned codes always report a zero result
   always_comb begin
      idle_res = dec_illegal ? '0 : core_res;
   end

   // One-bit step of the captured shift: zero fill for logical, sign fill for sra
   always_comb begin
      shift_nxt = shift_reg;
      case (shift_op)
         OP_SLL:  shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_nxt = {1'b0, shift_reg[WIDTH-1:1]};
         OP_SRA:  shift_nxt = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
         default: shift_nxt = shift_reg;
      endcase
   end

   // Control FSM with registered result; flush overrides every other event
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         shift_op    <= OP_SLL;
         shift_reg   <= '0;
         shift_cnt   <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (flush_i) begin
         state       <= IDLE;
         shift_cnt   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (dec_shift && (shamt != '0)) begin
                     shift_reg <= operand_a_i;
                     shift_cnt <= shamt;
                     shift_op  <= dec_op;
                     state     <= SHIFT;
                  end else begin
                     result_q    <= idle_res;
                     zero_q      <= (idle_res == '0);
                     illegal_q   <= dec_illegal;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            SHIFT: begin
               shift_reg <= shift_nxt;
               shift_cnt <= shift_cnt - 1'b1;
               if (shift_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                  result_q    <= shift_nxt;
                  zero_q      <= (shift_nxt == '0);
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table through a scoreboard plus
// hand-written backpressure, flush and reset sequences.
module tb_alu_seq;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        il;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        il;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_control = 4'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[18];

   alu_seq #(.WIDTH(32)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .alu_control_i (alu_control),
      .operand_a_i   (op_a),
      .operand_b_i   (op_b),
      .flush_i       (flush),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .result_o      (result),
      .zero_o        (zero),
      .illegal_o     (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: compare every consumed result against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got result %h with empty scoreboard", result);
         end else begin
            mon_e = sb_q.pop_front();
            chk("result", result, mon_e.res);
            chk("zero", {31'd0, zero}, {31'd0, mon_e.z});
            chk("illegal", {31'd0, illegal}, {31'd0, mon_e.il});
            if (mon_e.lat > 0)
               chk("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
         end
      end
   end

   // Wait for in_ready, present one request for exactly the accepting edge
   task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] er, input logic ez,
                        input logic ei, input int elat);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: in_ready got 0 expected 1 after %0d cycles", n);
         return;
      end
      in_valid    = 1'b1;
      alu_control = code;
      op_a        = a;
      op_b        = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) begin
         e.res = er;
         e.z   = ez;
         e.il  = ei;
         e.lat = elat;
         e.acc = cyc;
         sb_q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0 || out_valid) begin
         errors++;
         $display("FAIL drain_timeout: pending got %0d expected 0", sb_q.size());
      end
   endtask

   initial begin
      vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[2]  = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
      vecs[3]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[4]  = '{4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
      vecs[6]  = '{4'b0011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1};
      vecs[7]  = '{4'b0100, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0, 1};
      vecs[8]  = '{4'b0110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'b0110, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 5};
      vecs[10] = '{4'b1000, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
      vecs[11] = '{4'b1001, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
      vecs[12] = '{4'b1001, 32'h40000000, 32'h00000001, 32'h20000000, 1'b0, 1'b0, 2};
      vecs[13] = '{4'b1011, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
      vecs[14] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
      vecs[15] = '{4'b1000, 32'h000000F0, 32'h00000023, 32'h0000001E, 1'b0, 1'b0, 4};
      vecs[16] = '{4'b0110, 32'h80000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 2};
      vecs[17] = '{4'b1010, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1};

      // Reset values while held in reset
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // Table of single operations, consumer always ready
      for (int i = 0; i < 18; i++) begin
         issue(vecs[i].code, vecs[i].a, vecs[i].b, 1'b1,
               vecs[i].res, vecs[i].z, vecs[i].il, vecs[i].lat);
         drain();
      end

      // Result held in DONE under backpressure, no bypass on the consume cycle
      out_ready = 1'b0;
      issue(4'b0000, 32'd10, 32'd20, 1'b1, 32'd30, 1'b0, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_result", result, 32'd30);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("consume_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("post_consume_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_consume_out_valid", {31'd0, out_valid}, 32'd0);
      drain();

      // Flush at cycle 10 of srl by 20, with a competing request held up
      issue(4'b1000, 32'hFFFF0000, 32'd20, 1'b0, 32'd0, 1'b0, 1'b0, 0);
      repeat (9) @(negedge clk);
      flush       = 1'b1;
      in_valid    = 1'b1;
      alu_control = 4'b0000;
      op_a        = 32'd7;
      op_b        = 32'd7;
      #1;
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0;
      #1;
      chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (30) @(negedge clk);
      chk("flush_no_result", {31'd0, out_valid}, 32'd0);
      issue(4'b0000, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0, 1'b0, 1);
      drain();

      // Flush while a result waits in DONE discards it
      out_ready = 1'b0;
      issue(4'b0100, 32'h0000FFFF, 32'h000000FF, 1'b0, 32'd0, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("done_hold_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      chk("done_flush_out_valid", {31'd0, out_valid}, 32'd0);
      flush = 1'b0;
      #1;
      chk("done_flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;

      // Reset in the middle of a shift, then an unassigned code
      issue(4'b1001, 32'h80000000, 32'd20, 1'b0, 32'd0, 1'b0, 1'b0, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_zero", {31'd0, zero}, 32'd0);
      chk("midrst_illegal", {31'd0, illegal}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid    = 1'b1;
      alu_control = 4'b0000;
      op_a        = 32'd1;
      op_b        = 32'd1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_no_accept", {31'd0, out_valid}, 32'd0);
      rst_n = 1'b1;
      issue(4'b1100, 32'hDEADBEEF, 32'h00000003, 1'b1, 32'd0, 1'b1, 1'b1, 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; shift amount is always operand_b_i[4:0].
REQ-002 SHALL have ports:
- clk_i  input  1  sole clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  operation request valid.
- in_ready_o  output  1  unit can accept a request this cycle.
- alu_control_i  input  4  operation code (encoding in REQ-004).
- operand_a_i  input  WIDTH  first operand.
- operand_b_i  input  WIDTH  second operand / shift amount.
- flush_i  input  1  synchronous abort of any operation in flight.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  operation result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  accepted code was unassigned.

Function
REQ-003 SHALL accept a request on a rising edge where in_valid_i and in_ready_o are both 1, capturing the code and both operands.
REQ-004 SHALL decode: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed, result 1/0), 0110 sll, 0111 sltu, 1000 srl, 1001 sra, 1010 subu (a-b modulo 2^WIDTH; zero_o used for unsigned compare).
REQ-005 SHALL treat codes 1011-1111 as single-cycle ops with result_o=0, zero_o=1, illegal_o=1.
REQ-006 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready_o = (state==IDLE) && !flush_i.
REQ-007 IDLE: on accept of a non-shift op or of a shift with amount 0, compute result and go to DONE (out_valid_o high the next cycle, latency 1).
REQ-008 IDLE: on accept of a shift with amount k>0, load operand_a into a shift register, load k into a 5-bit counter, go to SHIFT.
REQ-009 SHIFT: each cycle shift one bit (sll: 0 in at LSB; srl: 0 in at MSB; sra: MSB replicated), decrement counter; on the cycle counter reaches 0, go to DONE; total latency k+1 cycles (shift 31 -> 32 cycles).
REQ-010 DONE: hold out_valid_o=1 and result_o/zero_o/illegal_o stable until out_ready_i=1; on that edge go to IDLE.
REQ-011 SHALL not accept a new request in the cycle a result is consumed (no bypass); next accept earliest one cycle later.
REQ-012 SHALL keep in_ready_o=0 in SHIFT and DONE.
REQ-013 flush_i=1 in any state SHALL force IDLE on the next edge, drop out_valid_o, discard the result; flush wins over simultaneous in_valid_i and out_ready_i.
REQ-014 zero_o and illegal_o SHALL be meaningful only while out_valid_o=1; result_o SHALL be registered (no combinational path from inputs to result_o).
REQ-015 add/sub/subu SHALL wrap modulo 2^WIDTH; carry/overflow are not reported.

Reset
REQ-016 rst_ni low SHALL asynchronously force state=IDLE, out_valid_o=0, result_o=0, zero_o=0, illegal_o=0, shift counter=0.
REQ-017 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; first accept possible on the first edge after rst_ni deasserts.
REQ-018 in_ready_o SHALL be 1 during reset (state IDLE), but no accept occurs while rst_ni is low.

Structure
REQ-019 Package alu_pkg SHALL hold the 4-bit operation enum (REQ-004 codes) and the FSM state enum; alu_decoder and alu_seq SHALL both use it.
REQ-020 Single-cycle arithmetic/logic SHALL live in combinational sub-module alu_core; FSM, shift register and counter stay in alu_seq.

Verification
REQ-021 add 0x7FFFFFFF + 0x00000001, out_ready_i=1 -> out_valid_o one cycle after accept, result 0x80000000, zero_o=0.
REQ-022 subu 5 - 5 -> result 0, zero_o=1; slt 0xFFFFFFFF vs 1 -> 1; sltu same operands -> 0.
REQ-023 sra 0x80000000 by 31 -> out_valid_o 32 cycles after accept, result 0xFFFFFFFF; sll by 0 -> latency 1, result = operand_a.
REQ-024 Result in DONE with out_ready_i=0 for 5 cycles -> result_o stable, in_ready_o=0; out_ready_i=1 -> IDLE, in_ready_o=1 next cycle.
REQ-025 flush_i pulsed at cycle 10 of srl by 20 -> IDLE next edge, no out_valid_o; following add 2+3 -> result 5.
REQ-026 rst_ni low mid-SHIFT, then code 1100 after release -> outputs reset values during reset; then result 0, zero_o=1, illegal_o=1.
